// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keycode decoder: receiver state
// encoding, scan-code-set-2 bytes, HID usage codes and the scan-to-HID map.
package ps2_pkg;

    // Frame receiver states
    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Prefix bytes
    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;

    // Non-extended scan codes
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_X     = 8'h22;
    localparam logic [7:0] SC_ESC   = 8'h76;

    // Extended (E0-prefixed) scan codes
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // HID usage codes presented to the game FSM
    localparam logic [7:0] HID_NONE  = 8'h00;
    localparam logic [7:0] HID_W     = 8'h1A;
    localparam logic [7:0] HID_A     = 8'h04;
    localparam logic [7:0] HID_S     = 8'h16;
    localparam logic [7:0] HID_D     = 8'h07;
    localparam logic [7:0] HID_ENTER = 8'h28;
    localparam logic [7:0] HID_X     = 8'h1B;
    localparam logic [7:0] HID_ESC   = 8'h29;
    localparam logic [7:0] HID_UP    = 8'h52;
    localparam logic [7:0] HID_DOWN  = 8'h51;
    localparam logic [7:0] HID_LEFT  = 8'h50;
    localparam logic [7:0] HID_RIGHT = 8'h4F;

    // Map a scan code to its HID usage; unmapped codes give HID_NONE.
    // The same byte means different keys depending on the E0 prefix.
    function automatic logic [7:0] translate(input logic ext, input logic [7:0] code);
        logic [7:0] hid;
        hid = HID_NONE;
        if (ext) begin
            case (code)
                SC_UP:    hid = HID_UP;
                SC_DOWN:  hid = HID_DOWN;
                SC_LEFT:  hid = HID_LEFT;
                SC_RIGHT: hid = HID_RIGHT;
                default:  hid = HID_NONE;
            endcase
        end else begin
            case (code)
                SC_W:     hid = HID_W;
                SC_A:     hid = HID_A;
                SC_S:     hid = HID_S;
                SC_D:     hid = HID_D;
                SC_ENTER: hid = HID_ENTER;
                SC_X:     hid = HID_X;
                SC_ESC:   hid = HID_ESC;
                default:  hid = HID_NONE;
            endcase
        end
        return hid;
    endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 byte receiver: synchronizes and deglitches the keyboard clock, frames
// start/data/parity/stop bits, checks odd parity and the stop bit, and aborts
// a frame whose clock stalls. Emits one-cycle byte_done or frame_err pulses.
module ps2_rx_byte
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] data_byte,
    output logic       byte_done,
    output logic       frame_err
);

    localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        clk_sync;
    logic [1:0]        dat_sync;
    logic              clk_filt;
    logic              clk_filt_d;
    logic [FILT_W-1:0] filt_cnt;
    logic              fall;
    logic              dat_bit;

    rx_state_t         state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_reg;
    logic              parity_ok;
    logic [TO_W-1:0]   to_cnt;

    // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1
    // NOTE: sequential blocks use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the two synchronizer stages into one.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
        end
    end

    // Clock deglitch: accept a new level only after FILTER_LEN equal samples
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_MAX) begin
                clk_filt <= ~clk_filt;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall    = clk_filt_d & ~clk_filt;
    assign dat_bit = dat_sync[1];

    // Frame FSM with parity/stop checking and mid-frame stall timeout
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            parity_ok <= 1'b0;
            to_cnt    <= '0;
            data_byte <= '0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;

            if (fall) begin
                // An edge always restarts the stall timer, so it can never
                // coincide with a timeout.
                to_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!dat_bit) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift_reg <= {dat_bit, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_ok <= ^{shift_reg, dat_bit};
                        state     <= STOP;
                    end
                    STOP: begin
                        if (parity_ok && dat_bit) begin
                            data_byte <= shift_reg;
                            byte_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (to_cnt == TO_MAX) begin
                    state     <= IDLE;
                    frame_err <= 1'b1;
                    to_cnt    <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_decoder.sv
// PS/2 keyboard front end for the game FSM: receives scan-code-set-2 bytes,
// tracks E0/F0 prefixes, translates mapped keys to HID usage codes and holds
// the currently pressed key on keycode (8'h00 when nothing is held).
module ps2_keycode_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       byte_done;
    logic       rx_err;
    logic       ext;
    logic       brk;
    logic [7:0] hid;

    ps2_rx_byte #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .Clk       (Clk),
        .Reset     (Reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .data_byte (rx_byte),
        .byte_done (byte_done),
        .frame_err (rx_err)
    );

    assign frame_err = rx_err;

    // Translate the received byte under the current extended prefix
    // NOTE: every variable written in always_comb gets a value on every
    // path (here a single unconditional assignment) so no latch is inferred.
    always_comb begin
        hid = translate(ext, rx_byte);
    end

    // Prefix tracking and hold register; key_valid marks any keycode change
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            keycode   <= HID_NONE;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (rx_err) begin
                // A corrupted or aborted frame may have been a prefix or a
                // code; drop any pending prefix rather than guess.
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_done) begin
                if (rx_byte == SC_E0) begin
                    ext <= 1'b1;
                end else if (rx_byte == SC_F0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (hid != HID_NONE) begin
                        if (!brk) begin
                            // Typematic repeats of the held key are silent
                            if (hid != keycode) begin
                                keycode   <= hid;
                                key_valid <= 1'b1;
                            end
                        end else if (hid == keycode) begin
                            // Only releasing the displayed key clears it
                            keycode   <= HID_NONE;
                            key_valid <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Self-checking bench for ps2_keycode_decoder: drives PS/2 frames bit by bit
// and compares keycode, key_valid and frame_err pulse counts against a
// key-press model built from the scan-code tables.
module tb_ps2_keycode_decoder;

    localparam int HALF = 16;   // Clk cycles per PS/2 clock half period

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic [7:0] keycode;
    logic       key_valid;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_keycode_decoder dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .keycode   (keycode),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    always #10 Clk = ~Clk;

    // Cycle counter and output pulse monitors, sampled on the falling edge
    int cyc = 0;
    int vpulse = 0;
    int epulse = 0;
    int wide_pulses = 0;
    int last_pulse_cyc = 0;
    int last_fall_cyc = 0;
    logic kv_prev = 1'b0;

    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        if (key_valid === 1'b1) begin
            vpulse++;
            last_pulse_cyc = cyc;
            if (kv_prev === 1'b1) wide_pulses++;
        end
        if (frame_err === 1'b1) epulse++;
        kv_prev = key_valid;
    end

    // Reference model: scan-code tables and the key currently held
    logic [7:0] map_n [logic [7:0]];
    logic [7:0] map_e [logic [7:0]];
    bit         m_ext = 0;
    bit         m_brk = 0;
    logic [7:0] m_key = 8'h00;
    int         exp_v = 0;
    int         exp_e = 0;

    function automatic logic [7:0] ref_map(input bit e, input logic [7:0] c);
        if (e) return map_e.exists(c) ? map_e[c] : 8'h00;
        return map_n.exists(c) ? map_n[c] : 8'h00;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] h;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            h = ref_map(m_ext, b);
            if (h != 8'h00 && !m_brk && h != m_key) begin
                m_key = h;
                exp_v++;
            end else if (h != 8'h00 && m_brk && h == m_key) begin
                m_key = 8'h00;
                exp_v++;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic model_err();
        m_ext = 0;
        m_brk = 0;
        exp_e++;
    endtask

    // One PS/2 bit: data set while the clock is high, then a low half period
    task automatic send_bit(input logic b);
        PS2_DAT = b;
        repeat (HALF) @(negedge Clk);
        PS2_CLK = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge Clk);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_parity);
        logic par;
        par = ~^b;
        if (bad_parity) par = ~par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(1'b1);
        PS2_DAT = 1'b1;
        repeat (3 * HALF) @(negedge Clk);
        if (bad_parity) model_err();
        else            model_byte(b);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        n_checks++;
        if (keycode !== 8'h00 || key_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: keycode=%h key_valid=%b frame_err=%b, required 00/0/0",
                     keycode, key_valid, frame_err);
        end
        Reset = 1'b1;
        repeat (5) @(negedge Clk);
    endtask

    task automatic test_make_break();
        send_frame(8'h1D, 0);
        n_checks++;
        if (keycode !== 8'h1A || vpulse != 1) begin
            n_fail++;
            $display("FAIL make_w: keycode=%h pulses=%0d, required 1a/1", keycode, vpulse);
        end
        n_checks++;
        if (last_pulse_cyc - last_fall_cyc < 1 || last_pulse_cyc - last_fall_cyc > 2 * HALF) begin
            n_fail++;
            $display("FAIL make_w_latency: pulse %0d cycles after stop edge, required 1..%0d",
                     last_pulse_cyc - last_fall_cyc, 2 * HALF);
        end
        send_frame(8'hF0, 0);
        n_checks++;
        if (keycode !== 8'h1A || vpulse != 1) begin
            n_fail++;
            $display("FAIL f0_alone: keycode=%h pulses=%0d, required 1a/1", keycode, vpulse);
        end
        send_frame(8'h1D, 0);
        n_checks++;
        if (keycode !== 8'h00 || vpulse != 2) begin
            n_fail++;
            $display("FAIL break_w: keycode=%h pulses=%0d, required 00/2", keycode, vpulse);
        end
    endtask

    task automatic test_extended();
        logic [7:0] seq [5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        for (int i = 0; i < 5; i++) begin
            send_frame(seq[i], 0);
            n_checks++;
            if (keycode !== m_key || vpulse != exp_v) begin
                n_fail++;
                $display("FAIL extended_%0d: keycode=%h pulses=%0d, required %h/%0d",
                         i, keycode, vpulse, m_key, exp_v);
            end
        end
        n_checks++;
        if (exp_v != 4) begin
            n_fail++;
            $display("FAIL extended_total: model pulses=%0d, required 4", exp_v);
        end
    endtask

    task automatic test_overlap();
        logic [7:0] seq [6]  = '{8'h1D, 8'h1C, 8'hF0, 8'h1D, 8'hF0, 8'h1C};
        logic [7:0] want [6] = '{8'h1A, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00};
        for (int i = 0; i < 6; i++) begin
            send_frame(seq[i], 0);
            n_checks++;
            if (keycode !== want[i] || vpulse != exp_v) begin
                n_fail++;
                $display("FAIL overlap_%0d: keycode=%h pulses=%0d, required %h/%0d",
                         i, keycode, vpulse, want[i], exp_v);
            end
        end
    endtask

    task automatic test_parity_err();
        send_frame(8'hE0, 0);
        send_frame(8'h1D, 1);
        n_checks++;
        if (keycode !== 8'h00 || epulse != exp_e || vpulse != exp_v) begin
            n_fail++;
            $display("FAIL parity_err: keycode=%h errs=%0d pulses=%0d, required 00/%0d/%0d",
                     keycode, epulse, vpulse, exp_e, exp_v);
        end
        send_frame(8'h1C, 0);
        n_checks++;
        if (keycode !== 8'h04) begin
            n_fail++;
            $display("FAIL after_parity_err: keycode=%h, required 04", keycode);
        end
    endtask

    task automatic test_timeout();
        send_frame(8'hE0, 0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        PS2_DAT = 1'b1;
        repeat (50500) @(negedge Clk);
        model_err();
        n_checks++;
        if (epulse != exp_e || keycode !== m_key) begin
            n_fail++;
            $display("FAIL timeout: errs=%0d keycode=%h, required %0d/%h",
                     epulse, keycode, exp_e, m_key);
        end
        send_frame(8'h5A, 0);
        n_checks++;
        if (keycode !== 8'h28 || epulse != exp_e) begin
            n_fail++;
            $display("FAIL after_timeout: keycode=%h errs=%0d, required 28/%0d",
                     keycode, epulse, exp_e);
        end
    endtask

    task automatic test_glitch();
        PS2_DAT = 1'b0;
        repeat (4) @(negedge Clk);
        PS2_CLK = 1'b0;
        repeat (3) @(negedge Clk);
        PS2_CLK = 1'b1;
        repeat (4) @(negedge Clk);
        PS2_DAT = 1'b1;
        repeat (2 * HALF) @(negedge Clk);
        send_frame(8'h1B, 0);
        n_checks++;
        if (keycode !== 8'h16 || epulse != exp_e || vpulse != exp_v) begin
            n_fail++;
            $display("FAIL glitch: keycode=%h errs=%0d pulses=%0d, required 16/%0d/%0d",
                     keycode, epulse, vpulse, exp_e, exp_v);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        n_checks++;
        if (keycode !== 8'h00 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: keycode=%h key_valid=%b, required 00/0", keycode, key_valid);
        end
        Reset = 1'b1;
        PS2_DAT = 1'b1;
        m_key = 8'h00;
        m_ext = 0;
        m_brk = 0;
        repeat (2 * HALF) @(negedge Clk);
        send_frame(8'h1D, 0);
        n_checks++;
        if (keycode !== 8'h1A || vpulse != exp_v || epulse != exp_e) begin
            n_fail++;
            $display("FAIL after_reset_mid: keycode=%h pulses=%0d errs=%0d, required 1a/%0d/%0d",
                     keycode, vpulse, epulse, exp_v, exp_e);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [14] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h5A, 8'h22, 8'h76,
                                  8'h75, 8'h72, 8'h6B, 8'h74, 8'h15, 8'hE0, 8'hF0};
        logic [7:0] b;
        bit         bad;
        for (int i = 0; i < 24; i++) begin
            b   = pool[$urandom_range(13, 0)];
            bad = ($urandom_range(7, 0) == 0);
            send_frame(b, bad);
            n_checks++;
            if (keycode !== m_key || vpulse != exp_v || epulse != exp_e) begin
                n_fail++;
                $display("FAIL random_%0d byte=%h bad=%0d: keycode=%h pulses=%0d errs=%0d, required %h/%0d/%0d",
                         i, b, bad, keycode, vpulse, epulse, m_key, exp_v, exp_e);
            end
        end
        n_checks++;
        if (wide_pulses != 0) begin
            n_fail++;
            $display("FAIL pulse_width: %0d key_valid pulses longer than one cycle, required 0",
                     wide_pulses);
        end
    endtask

    initial begin
        map_n[8'h1D] = 8'h1A;  map_n[8'h1C] = 8'h04;  map_n[8'h1B] = 8'h16;
        map_n[8'h23] = 8'h07;  map_n[8'h5A] = 8'h28;  map_n[8'h22] = 8'h1B;
        map_n[8'h76] = 8'h29;
        map_e[8'h75] = 8'h52;  map_e[8'h72] = 8'h51;  map_e[8'h6B] = 8'h50;
        map_e[8'h74] = 8'h4F;

        test_reset();
        test_make_break();
        test_extended();
        test_overlap();
        test_parity_err();
        test_timeout();
        test_glitch();
        test_reset_mid_frame();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
